// File: rtl/response_uart_tx.sv
// rtl/response_uart_tx.sv - UART transmitter for the PUF response with an ack/clear handshake
// Optional macro UART_PARITY_EN inserts an even-parity bit between the data and stop bits.
module response_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ACK_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  response,
  input  logic        ready_to_read,
  output logic        tx,
  output logic        computer_ack_reset,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frames_sent
);

  localparam int CNT_MAX = (CLKS_PER_BIT > ACK_CYCLES) ? CLKS_PER_BIT : ACK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_AT   = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_CYCLES - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_CLR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_ACK, S_WAIT_CLR
  } state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift_r, shift_nxt;
  logic          tx_nxt, ack_nxt, busy_nxt, done_nxt, frame_end;
`ifdef UART_PARITY_EN
  logic          parity_r, parity_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= S_IDLE;
      baud_cnt           <= '0;
      bit_idx            <= '0;
      shift_r            <= '0;
      tx                 <= 1'b1;
      computer_ack_reset <= 1'b0;
      busy               <= 1'b0;
      tx_done            <= 1'b0;
`ifdef UART_PARITY_EN
      parity_r           <= 1'b0;
`endif
    end else begin
      state              <= state_nxt;
      baud_cnt           <= baud_nxt;
      bit_idx            <= bit_nxt;
      shift_r            <= shift_nxt;
      tx                 <= tx_nxt;
      computer_ack_reset <= ack_nxt;
      busy               <= busy_nxt;
      tx_done            <= done_nxt;
`ifdef UART_PARITY_EN
      parity_r           <= parity_nxt;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset)          frames_sent <= '0;
    else if (frame_end) frames_sent <= frames_sent + 16'd1;
  end

  // Outputs are computed one cycle ahead so every output leaves straight from a flop.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift_r;
    tx_nxt    = tx;
    ack_nxt   = computer_ack_reset;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    frame_end = 1'b0;
`ifdef UART_PARITY_EN
    parity_nxt = parity_r;
`endif
    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b1;
        ack_nxt  = 1'b0;
        busy_nxt = 1'b0;
        if (ready_to_read) begin
          shift_nxt = response;
`ifdef UART_PARITY_EN
          parity_nxt = ^response;
`endif
          state_nxt = S_START;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      S_START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = S_DATA;
          tx_nxt    = shift_r[0];
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt = S_PARITY;
            tx_nxt    = parity_r;
`else
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            shift_nxt = {1'b0, shift_r[7:1]};
            tx_nxt    = shift_r[1];
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
`endif
      S_STOP: begin
        done_nxt = (baud_cnt == DONE_AT);
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = S_ACK;
          ack_nxt   = 1'b1;
          frame_end = 1'b1;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      S_ACK: begin
        if (baud_cnt == ACK_LAST) begin
          baud_nxt  = '0;
          ack_nxt   = 1'b0;
          state_nxt = S_WAIT_CLR;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      S_WAIT_CLR: begin
        // Hold off until the buffer has visibly cleared, so a stale byte is never resent.
        if (!ready_to_read) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
        ack_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        baud_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_response_uart_tx.sv
// tb/tb_response_uart_tx.sv - directed self-checking bench for response_uart_tx
// Build with or without UART_PARITY_EN; expectations follow the same macro.
module tb_response_uart_tx;

  localparam int CPB = 4;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  response;
  logic        ready_to_read;
  logic        tx;
  logic        computer_ack_reset;
  logic        busy;
  logic        tx_done;
  logic [15:0] frames_sent;

  int n_cmp = 0;
  int n_err = 0;

  response_uart_tx #(.CLKS_PER_BIT(CPB), .ACK_CYCLES(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .response           (response),
    .ready_to_read      (ready_to_read),
    .tx                 (tx),
    .computer_ack_reset (computer_ack_reset),
    .busy               (busy),
    .tx_done            (tx_done),
    .frames_sent        (frames_sent)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts a frame from IDLE and checks it clock by clock through ACK and WAIT_CLR.
  task automatic run_frame(input logic [7:0] data, input logic [15:0] exp_frames,
                           input bit hold, input bit do_change, input logic [7:0] change_to);
    logic [10:0] bits;
    bits       = '1;
    bits[0]    = 1'b0;
    bits[8:1]  = data;
`ifdef UART_PARITY_EN
    bits[9]    = ^data;
`endif
    response      = data;
    ready_to_read = 1'b1;
    step();
    if (!hold) ready_to_read = 1'b0;
    for (int c = 0; c < FL; c++) begin
      check_eq($sformatf("tx_c%0d", c), tx, bits[c / CPB]);
      check_eq($sformatf("done_c%0d", c), tx_done, (c == FL - 1));
      check_eq($sformatf("ack_c%0d", c), computer_ack_reset, 0);
      check_eq($sformatf("busy_c%0d", c), busy, 1);
      if (do_change && c == 12) response = change_to;
      step();
    end
    check_eq("ack_rise", computer_ack_reset, 1);
    check_eq("done_clear", tx_done, 0);
    check_eq("frames", frames_sent, exp_frames);
    check_eq("tx_ack", tx, 1);
    step();
    check_eq("ack_hold", computer_ack_reset, 1);
    step();
    check_eq("ack_fall", computer_ack_reset, 0);
    check_eq("busy_waitclr", busy, 1);
    step();
    check_eq("busy_end", busy, hold ? 1 : 0);
    check_eq("frames_end", frames_sent, exp_frames);
  endtask

  initial begin
    reset         = 1'b1;
    ready_to_read = 1'b0;
    response      = 8'h00;
    step();
    step();
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", computer_ack_reset, 0);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_frames", frames_sent, 0);
    reset = 1'b0;
    step();

    // Abort after three data bits have gone out.
    response      = 8'h5A;
    ready_to_read = 1'b1;
    step();
    ready_to_read = 1'b0;
    check_eq("abort_start", tx, 0);
    for (int i = 0; i < 4 + 3 * CPB; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_tx", tx, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_frames", frames_sent, 0);
    for (int i = 0; i < 20; i++) begin
      check_eq("abort_noack", computer_ack_reset, 0);
      check_eq("abort_idle_tx", tx, 1);
      step();
    end

    run_frame(8'hA5, 16'd1, 1'b0, 1'b0, 8'h00);
    run_frame(8'h07, 16'd2, 1'b0, 1'b0, 8'h00);
    run_frame(8'h3C, 16'd3, 1'b0, 1'b1, 8'hFF);

    // Stale hold: ready_to_read stays high past the ack.
    run_frame(8'h81, 16'd4, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      check_eq("hold_tx", tx, 1);
      check_eq("hold_busy", busy, 1);
      check_eq("hold_ack", computer_ack_reset, 0);
      step();
    end
    ready_to_read = 1'b0;
    step();
    check_eq("hold_release", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_idle_tx", tx, 1);
      check_eq("hold_idle_busy", busy, 0);
    end
    check_eq("hold_frames", frames_sent, 4);

    force dut.frames_sent = 16'hFFFF;
    #1;
    release dut.frames_sent;
    #1;
    check_eq("wrap_pre", frames_sent, 16'hFFFF);
    run_frame(8'h00, 16'd0, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
